// File: rtl/vga_rect_fill.sv
// Rectangle-fill drawing engine: one command per handshake, one pixel write per clock in raster order.
// Optional RECT_CLIP_EN macro clips rectangles to the HD x VD visible area at accept time.
module vga_rect_fill #(
  parameter int HD         = 1280,
  parameter int VD         = 1024,
  parameter int COORD_BITS = 11
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [COORD_BITS-1:0] cmd_x_i,
  input  logic [COORD_BITS-1:0] cmd_y_i,
  input  logic [COORD_BITS-1:0] cmd_w_i,
  input  logic [COORD_BITS-1:0] cmd_h_i,
  input  logic [1:0]            cmd_color_i,
  input  logic                  abort_i,
  output logic [COORD_BITS-1:0] addr_x_o,
  output logic [COORD_BITS-1:0] addr_y_o,
  output logic [1:0]            color_o,
  output logic                  we_o,
  output logic                  busy_o,
  output logic                  done_o
);

`ifdef RECT_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam logic [COORD_BITS-1:0] HD_C = COORD_BITS'(HD);
  localparam logic [COORD_BITS-1:0] VD_C = COORD_BITS'(VD);
  localparam logic [COORD_BITS-1:0] ONE  = COORD_BITS'(1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t                state_q, state_d;
  logic [COORD_BITS-1:0] x_q, y_q, w_q, h_q, col_q, row_q;
  logic [COORD_BITS-1:0] x_d, y_d, w_d, h_d, col_d, row_d;
  logic [1:0]            color_q, color_d;
  logic [COORD_BITS-1:0] w_eff, h_eff;
  logic                  accept, last_col, last_row;

  assign cmd_ready_o = (state_q == IDLE);
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign last_col    = (col_q == w_q - ONE);
  assign last_row    = (row_q == h_q - ONE);

  // Clipping happens once at accept so the fill loop never needs a bound check.
  always_comb begin
    w_eff = cmd_w_i;
    h_eff = cmd_h_i;
    if (CLIP_EN) begin
      if (cmd_x_i >= HD_C)                 w_eff = '0;
      else if (cmd_w_i > HD_C - cmd_x_i)   w_eff = HD_C - cmd_x_i;
      if (cmd_y_i >= VD_C)                 h_eff = '0;
      else if (cmd_h_i > VD_C - cmd_y_i)   h_eff = VD_C - cmd_y_i;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      col_q   <= col_d;
      row_q   <= row_d;
      color_q <= color_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    col_d   = col_q;
    row_d   = row_q;
    color_d = color_q;
    case (state_q)
      IDLE: if (accept) begin
        x_d     = cmd_x_i;
        y_d     = cmd_y_i;
        w_d     = w_eff;
        h_d     = h_eff;
        color_d = cmd_color_i;
        col_d   = '0;
        row_d   = '0;
        state_d = (w_eff != '0 && h_eff != '0) ? FILL : DONE;
      end
      FILL: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (last_col) begin
          col_d = '0;
          row_d = row_q + ONE;
          if (last_row) state_d = DONE;
        end else begin
          col_d = col_q + ONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_o     = (state_q == FILL);
    done_o   = (state_q == DONE);
    busy_o   = (state_q != IDLE);
    addr_x_o = x_q + col_q;
    addr_y_o = y_q + row_q;
    color_o  = color_q;
  end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill; expectations follow RECT_CLIP_EN when it is defined.
module tb_vga_rect_fill;
  logic        clk_i = 1'b0;
  logic        arst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [10:0] cmd_x_i, cmd_y_i, cmd_w_i, cmd_h_i;
  logic [1:0]  cmd_color_i;
  logic        abort_i;
  logic [10:0] addr_x_o, addr_y_o;
  logic [1:0]  color_o;
  logic        we_o, busy_o, done_o;

  int vecs = 0;
  int errs = 0;

  vga_rect_fill dut (
    .clk_i(clk_i), .arst_i(arst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_x_i(cmd_x_i), .cmd_y_i(cmd_y_i), .cmd_w_i(cmd_w_i), .cmd_h_i(cmd_h_i),
    .cmd_color_i(cmd_color_i), .abort_i(abort_i), .addr_x_o(addr_x_o), .addr_y_o(addr_y_o),
    .color_o(color_o), .we_o(we_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_cmd(input int x, input int y, input int w, input int h, input int c);
    cmd_x_i     = 11'(x);
    cmd_y_i     = 11'(y);
    cmd_w_i     = 11'(w);
    cmd_h_i     = 11'(h);
    cmd_color_i = 2'(c);
  endtask

  // Issue one command and check every write of an ew x eh raster, then done and ready.
  task automatic do_cmd(input string tag, input int x, input int y, input int w, input int h,
                        input int c, input int ew, input int eh);
    set_cmd(x, y, w, h, c);
    cmd_valid_i = 1'b1;
    check({tag, "_ready_pre"}, 32'(cmd_ready_o), 1);
    step();
    cmd_valid_i = 1'b0;
    for (int i = 0; i < ew * eh; i++) begin
      check({tag, "_we"},    32'(we_o),     1);
      check({tag, "_x"},     32'(addr_x_o), 32'((x + i % ew) % 2048));
      check({tag, "_y"},     32'(addr_y_o), 32'((y + i / ew) % 2048));
      check({tag, "_color"}, 32'(color_o),  32'(c));
      check({tag, "_nodone"},32'(done_o),   0);
      step();
    end
    check({tag, "_we_off"}, 32'(we_o),        0);
    check({tag, "_done"},   32'(done_o),      1);
    check({tag, "_busy"},   32'(busy_o),      1);
    check({tag, "_rdy_lo"}, 32'(cmd_ready_o), 0);
    step();
    check({tag, "_done_off"}, 32'(done_o),      0);
    check({tag, "_ready"},    32'(cmd_ready_o), 1);
    check({tag, "_idle"},     32'(busy_o),      0);
  endtask

  initial begin
    arst_i = 1'b1; cmd_valid_i = 1'b0; abort_i = 1'b0;
    set_cmd(0, 0, 0, 0, 0);
    #12;
    check("rst_we",    32'(we_o),     0);
    check("rst_done",  32'(done_o),   0);
    check("rst_busy",  32'(busy_o),   0);
    check("rst_x",     32'(addr_x_o), 0);
    check("rst_y",     32'(addr_y_o), 0);
    check("rst_color", 32'(color_o),  0);
    check("rst_ready", 32'(cmd_ready_o), 1);
    arst_i = 1'b0;
    step();

    do_cmd("t1", 10, 20, 3, 2, 2, 3, 2);
    do_cmd("t2", 0, 0, 0, 5, 1, 0, 5);
    do_cmd("t2h", 4, 4, 7, 0, 3, 7, 0);

    // Two queued 1x1 commands with valid held high
    set_cmd(5, 5, 1, 1, 1);
    cmd_valid_i = 1'b1;
    step();
    check("t3_we1", 32'(we_o), 1);
    check("t3_x1",  32'(addr_x_o), 5);
    check("t3_rdy1", 32'(cmd_ready_o), 0);
    set_cmd(7, 8, 1, 1, 3);
    step();
    check("t3_done1", 32'(done_o), 1);
    check("t3_rdy2",  32'(cmd_ready_o), 0);
    check("t3_col_hold", 32'(color_o), 1);
    step();
    check("t3_we_gap", 32'(we_o), 0);
    check("t3_rdy3",   32'(cmd_ready_o), 1);
    step();
    cmd_valid_i = 1'b0;
    check("t3_we2",   32'(we_o), 1);
    check("t3_x2",    32'(addr_x_o), 7);
    check("t3_y2",    32'(addr_y_o), 8);
    check("t3_c2",    32'(color_o), 3);
    step();
    check("t3_done2", 32'(done_o), 1);
    step();

    // 4x4 fill aborted during its 6th write
    set_cmd(100, 200, 4, 4, 1);
    cmd_valid_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t4_we", 32'(we_o), 1);
      step();
    end
    check("t4_we6", 32'(we_o), 1);
    check("t4_x6",  32'(addr_x_o), 101);
    check("t4_y6",  32'(addr_y_o), 201);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("t4_we_off", 32'(we_o), 0);
    check("t4_nodone", 32'(done_o), 0);
    check("t4_ready",  32'(cmd_ready_o), 1);
    step();
    check("t4_nodone2", 32'(done_o), 0);
    // abort asserted at accept time must not cancel the new command
    set_cmd(50, 60, 2, 1, 2);
    cmd_valid_i = 1'b1;
    abort_i     = 1'b1;
    step();
    cmd_valid_i = 1'b0;
    abort_i     = 1'b0;
    check("t4b_we", 32'(we_o), 1);
    check("t4b_x",  32'(addr_x_o), 50);
    step();
    check("t4b_x2", 32'(addr_x_o), 51);
    step();
    check("t4b_done", 32'(done_o), 1);
    step();

`ifdef RECT_CLIP_EN
    do_cmd("t5_edge", 1278, 0, 5, 1, 3, 2, 1);
    do_cmd("t5_off",  1300, 0, 5, 1, 3, 0, 1);
    do_cmd("t5_offy", 0, 1030, 2, 2, 1, 2, 0);
    do_cmd("t5_ybot", 0, 1022, 1, 4, 2, 1, 2);
`else
    do_cmd("t5_edge", 1278, 0, 5, 1, 3, 5, 1);
    do_cmd("t5_wrap", 2046, 2047, 4, 2, 1, 4, 2);
`endif

    // Asynchronous reset in the middle of an 8x8 fill
    set_cmd(0, 0, 8, 8, 2);
    cmd_valid_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
    step();
    step();
    check("t6_we_pre", 32'(we_o), 1);
    #3;
    arst_i = 1'b1;
    #1;
    check("t6_we",   32'(we_o),   0);
    check("t6_done", 32'(done_o), 0);
    check("t6_busy", 32'(busy_o), 0);
    step();
    arst_i = 1'b0;
    step();
    check("t6_ready", 32'(cmd_ready_o), 1);
    check("t6_nodone", 32'(done_o), 0);
    do_cmd("t6_after", 30, 40, 2, 2, 1, 2, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
